// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants, FSM state type and digit helper for the
//               digit-serial BCD adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int BCD_DIGIT_W   = 4;
   localparam int BCD_MAX_DIGIT = 9;
   localparam int BCD_CORR      = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bcd_state_t;

   // A nibble is a legal BCD digit only in the range 0..9.
   function automatic logic bcd_invalid(input logic [BCD_DIGIT_W-1:0] d);
      return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
   endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
// ============================================================================
// Module      : bcd_digit_cell
// Description : Combinational single-digit decimal-corrected adder cell, with
//               optional 9's-complement operand path (macro BCD_SUB_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a_dig,
   input  logic [BCD_DIGIT_W-1:0] b_dig,
   input  logic                   carry_in,
   input  logic                   sub,
   output logic [BCD_DIGIT_W-1:0] sum,
   output logic                   carry_out,
   output logic                   invalid
);

   logic [BCD_DIGIT_W-1:0] w_bv;
   logic [BCD_DIGIT_W:0]   w_raw;
   logic                   w_gt9;

`ifdef BCD_SUB_EN
   // 9's complement wraps modulo 16 for out-of-range b digits.
   assign w_bv = sub ? (BCD_DIGIT_W'(BCD_MAX_DIGIT) - b_dig) : b_dig;
`else
   logic w_sub_unused;
   assign w_sub_unused = sub;
   assign w_bv         = b_dig;
`endif

   assign w_raw = {1'b0, a_dig} + {1'b0, w_bv} + {{BCD_DIGIT_W{1'b0}}, carry_in};
   assign w_gt9 = w_raw > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT);

   assign sum       = w_gt9 ? (w_raw[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR))
                            : w_raw[BCD_DIGIT_W-1:0];
   assign carry_out = w_gt9;
   assign invalid   = bcd_invalid(a_dig) | bcd_invalid(b_dig);

endmodule : bcd_digit_cell

`default_nettype wire

// File: rtl/bcd_serial_adder.sv
// ============================================================================
// Module      : bcd_serial_adder
// Description : Digit-serial multi-digit BCD adder with start/done handshake;
//               optional subtraction enabled by macro BCD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
   input  logic                          cin,
   input  logic                          sub,
   output logic [BCD_DIGIT_W*DIGITS-1:0] s,
   output logic                          cout,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int c_data_w = BCD_DIGIT_W * DIGITS;
   localparam int c_idx_w  = $clog2(DIGITS + 1);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

   bcd_state_t              r_state;
   logic [c_data_w-1:0]     r_a;
   logic [c_data_w-1:0]     r_b;
   logic [c_data_w-1:0]     r_res;
   logic                    r_sub;
   logic                    r_carry;
   logic                    r_err_acc;
   logic [c_idx_w-1:0]      r_idx;

   logic                    w_sub_req;
   logic [BCD_DIGIT_W-1:0]  w_cell_sum;
   logic                    w_cell_cout;
   logic                    w_cell_inv;
   logic [c_data_w-1:0]     w_a_next;
   logic [c_data_w-1:0]     w_b_next;
   logic [c_data_w-1:0]     w_res_next;

`ifdef BCD_SUB_EN
   assign w_sub_req = sub;
`else
   logic w_sub_unused;
   assign w_sub_unused = sub;
   assign w_sub_req    = 1'b0;
`endif

   bcd_digit_cell u_cell (
      .a_dig     (r_a[BCD_DIGIT_W-1:0]),
      .b_dig     (r_b[BCD_DIGIT_W-1:0]),
      .carry_in  (r_carry),
      .sub       (r_sub),
      .sum       (w_cell_sum),
      .carry_out (w_cell_cout),
      .invalid   (w_cell_inv)
   );

   // Operands drain towards digit 0; results enter at the top so that after
   // DIGITS shifts digit 0 sits in the low nibble.
   generate
      if (DIGITS == 1) begin : g_single
         assign w_a_next   = '0;
         assign w_b_next   = '0;
         assign w_res_next = w_cell_sum;
      end else begin : g_multi
         assign w_a_next   = {{BCD_DIGIT_W{1'b0}}, r_a[c_data_w-1:BCD_DIGIT_W]};
         assign w_b_next   = {{BCD_DIGIT_W{1'b0}}, r_b[c_data_w-1:BCD_DIGIT_W]};
         assign w_res_next = {w_cell_sum, r_res[c_data_w-1:BCD_DIGIT_W]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_res     <= '0;
         r_sub     <= 1'b0;
         r_carry   <= 1'b0;
         r_err_acc <= 1'b0;
         r_idx     <= '0;
         s         <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_sub     <= w_sub_req;
                  r_carry   <= w_sub_req ? 1'b1 : cin;
                  r_idx     <= '0;
                  r_err_acc <= 1'b0;
                  busy      <= 1'b1;
                  r_state   <= RUN;
               end
            end
            RUN: begin
               r_a       <= w_a_next;
               r_b       <= w_b_next;
               r_res     <= w_res_next;
               r_carry   <= w_cell_cout;
               r_err_acc <= r_err_acc | w_cell_inv;
               r_idx     <= r_idx + c_idx_w'(1);
               if (r_idx == c_last_idx) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               s       <= r_res;
               cout    <= r_carry;
               err     <= r_err_acc;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : bcd_serial_adder

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// ============================================================================
// Module      : tb_bcd_serial_adder
// Description : Directed self-checking bench for bcd_serial_adder (DIGITS=4);
//               expectations follow BCD_SUB_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_adder;

   localparam int DIGITS = 4;

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] s;
   logic        cout;
   logic        busy;
   logic        done;
   logic        err;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .s     (s),
      .cout  (cout),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_s"},    32'(s),    32'h0);
      check({tag, "_cout"}, 32'(cout), 32'h0);
      check({tag, "_err"},  32'(err),  32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
   endtask

   // One operation: start sampled at edge 0; operands scrambled afterwards.
   task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub,
                         input logic [15:0] es, input logic ec, input logic ee,
                         input int glitch_edge, input int rst_edge);
      exp_t item;
      logic got;
      a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
      @(posedge clk);
      sb.push_back('{s: es, cout: ec, err: ee});
      #1;
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      check({name, "_busy_e0"}, 32'(busy), 32'h1);
      check({name, "_done_e0"}, 32'(done), 32'h0);
      got = 1'b0;
      for (int e = 1; e <= DIGITS + 4 && !got; e++) begin
         start = (e == glitch_edge);
         if (start) begin
            a = 16'h9999; b = 16'h9999;
         end
         rst = (e == rst_edge);
         @(posedge clk);
         #1;
         start = 1'b0;
         if (e == rst_edge) begin
            rst = 1'b0;
            check_idle_zero({name, "_abort"});
            void'(sb.pop_back());
            return;
         end
         if (done) begin
            got = 1'b1;
            check({name, "_done_edge"}, 32'(e), 32'(DIGITS + 1));
            check({name, "_busy_end"}, 32'(busy), 32'h0);
            check({name, "_sb_nonempty"}, 32'(sb.size() > 0), 32'h1);
            if (sb.size() > 0) begin
               item = sb.pop_front();
               check({name, "_s"},    32'(s),    32'(item.s));
               check({name, "_cout"}, 32'(cout), 32'(item.cout));
               check({name, "_err"},  32'(err),  32'(item.err));
            end
         end else if (e <= DIGITS) begin
            check({name, "_busy_run"}, 32'(busy), 32'h1);
         end
      end
      check({name, "_done_seen"}, 32'(got), 32'h1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check({name, "_no_extra_done"}, 32'(done), 32'h0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst = 1'b0;

      run_op("add_basic",  16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, -1, -1);
      run_op("add_wrap",   16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, -1, -1);
      run_op("add_max",    16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, -1, -1);
      run_op("add_cin",    16'h0008, 16'h0001, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, -1, -1);
      run_op("bad_digit",  16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1, -1, -1);
      run_op("after_bad",  16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, -1, -1);
      run_op("busy_start", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0,  2, -1);
      run_op("abort",      16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, -1,  3);
      run_op("after_rst",  16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, -1, -1);
`ifdef BCD_SUB_EN
      run_op("sub_pos",    16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b1, 1'b0, -1, -1);
      run_op("sub_neg",    16'h0123, 16'h0500, 1'b0, 1'b1, 16'h9623, 1'b0, 1'b0, -1, -1);
`else
      run_op("sub_pos",    16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0, -1, -1);
      run_op("sub_neg",    16'h0123, 16'h0500, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0, -1, -1);
`endif
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bcd_serial_adder

`default_nettype wire
